// File: rtl/irq_controller_pkg.sv
// Shared constants for the interrupt controller: state encodings, register offsets, id width.
package irq_controller_pkg;

   // Width of the in-service interrupt index
   localparam int unsigned IrqIdSize = 5;

   // Controller FSM state encoding
   typedef logic [1:0] irq_state_t;
   localparam irq_state_t IRQ_IDLE    = 2'd0;
   localparam irq_state_t IRQ_REQ     = 2'd1;
   localparam irq_state_t IRQ_SERVICE = 2'd2;

   // Word offsets of the register window
   localparam logic [1:0] IRQ_PENDING = 2'd0;
   localparam logic [1:0] IRQ_ENABLE  = 2'd1;
   localparam logic [1:0] IRQ_CLAIM   = 2'd2;
   localparam logic [1:0] IRQ_TRIG    = 2'd3;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source two-flop synchroniser followed by rising-edge or level detection.
module irq_sync_edge #(
   parameter bit IsEdge = 1'b1
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic src_i,
   output logic rise_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   // Synchroniser chain plus the previous-sample register for edge detection
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= src_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Edge sources fire once per rising edge; level sources follow the synchronised line
   always_comb begin
      if (IsEdge) begin
         rise_o = sync2_q & ~prev_q;
      end else begin
         rise_o = sync2_q;
      end
   end

endmodule

// File: rtl/irq_controller.sv
// Interrupt aggregator: synchronises sources, latches pending bits, arbitrates by fixed
// priority (lowest index wins) and runs a request/ack/complete handshake with the core.
module irq_controller
   import irq_controller_pkg::*;
#(
   parameter int unsigned        DATA_WIDTH = 32,
   parameter int unsigned        NUM_SRC    = 8,
   parameter logic [NUM_SRC-1:0] EDGE_MASK  = 8'hFF
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [NUM_SRC-1:0]    src_i,
   output logic                  irq_o,
   input  logic                  ack_i,
   input  logic                  complete_i,
   output logic [IrqIdSize-1:0]  id_o,
   input  logic [1:0]            addr_i,
   input  logic                  wr_i,
   input  logic                  rd_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] data_o
);

   logic [NUM_SRC-1:0]    rise;
   logic [NUM_SRC-1:0]    pending_q, pending_d;
   logic [NUM_SRC-1:0]    enable_q, enable_d;
   logic [NUM_SRC-1:0]    active;
   logic [NUM_SRC-1:0]    w1c;
   logic [NUM_SRC-1:0]    ack_clr;
   logic [IrqIdSize-1:0]  sel_id;
   logic [IrqIdSize-1:0]  id_q, id_d;
   irq_state_t            state_q, state_d;
   logic                  ack_take;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [DATA_WIDTH-1:0] data_q;

   for (genvar g = 0; g < NUM_SRC; g++) begin : gen_src
      irq_sync_edge #(
         .IsEdge (EDGE_MASK[g])
      ) u_sync (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .src_i   (src_i[g]),
         .rise_o  (rise[g])
      );
   end

   assign active   = pending_q & enable_q;
   assign ack_take = (state_q == IRQ_REQ) && ack_i;

   // Priority encoder: scan downwards so the lowest set index is the last one written
   always_comb begin
      sel_id = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (active[i]) begin
            sel_id = IrqIdSize'(i);
         end
      end
   end

   // Pending update: edge bits are sticky with clear, level bits track the line; set wins
   always_comb begin
      w1c = '0;
      if (wr_i && (addr_i == IRQ_PENDING)) begin
         w1c = data_i[NUM_SRC-1:0];
      end
      ack_clr = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         ack_clr[i] = ack_take && active[i] && (sel_id == IrqIdSize'(i));
      end
      pending_d = (EDGE_MASK & ((pending_q & ~(w1c | ack_clr)) | rise)) | (~EDGE_MASK & rise);
   end

   // Enable register write
   always_comb begin
      enable_d = enable_q;
      if (wr_i && (addr_i == IRQ_ENABLE)) begin
         enable_d = data_i[NUM_SRC-1:0];
      end
   end

   // Handshake FSM; an ack in REQ always wins over a simultaneous loss of requests
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      unique case (state_q)
         IRQ_IDLE: begin
            if (active != '0) begin
               state_d = IRQ_REQ;
            end
         end
         IRQ_REQ: begin
            if (ack_i) begin
               state_d = IRQ_SERVICE;
               id_d    = sel_id;
            end else if (active == '0) begin
               state_d = IRQ_IDLE;
            end
         end
         IRQ_SERVICE: begin
            if (complete_i) begin
               state_d = IRQ_IDLE;
            end
         end
         default: state_d = IRQ_IDLE;
      endcase
   end

   // Register window read mux
   always_comb begin
      rd_data = '0;
      unique case (addr_i)
         IRQ_PENDING: rd_data[NUM_SRC-1:0] = pending_q;
         IRQ_ENABLE:  rd_data[NUM_SRC-1:0] = enable_q;
         IRQ_CLAIM: begin
            rd_data[31]            = (state_q == IRQ_SERVICE);
            rd_data[IrqIdSize-1:0] = id_q;
         end
         IRQ_TRIG:    rd_data[NUM_SRC-1:0] = EDGE_MASK;
      endcase
   end

   // State registers
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         pending_q <= '0;
         enable_q  <= '0;
         id_q      <= '0;
         state_q   <= IRQ_IDLE;
         data_q    <= '0;
      end else begin
         pending_q <= pending_d;
         enable_q  <= enable_d;
         id_q      <= id_d;
         state_q   <= state_d;
         if (rd_i) begin
            data_q <= rd_data;
         end
      end
   end

   assign irq_o  = (state_q == IRQ_REQ);
   assign id_o   = id_q;
   assign data_o = data_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller (source 4 configured as level-triggered).
module tb_irq_controller;

   logic        clk;
   logic        reset;
   logic [7:0]  src;
   logic        irq;
   logic        ack;
   logic        complete;
   logic [4:0]  id;
   logic [1:0]  addr;
   logic        wr;
   logic        rd;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [31:0] val;

   int n_checks = 0;
   int n_errors = 0;

   irq_controller #(
      .DATA_WIDTH (32),
      .NUM_SRC    (8),
      .EDGE_MASK  (8'hEF)
   ) dut (
      .clk_i      (clk),
      .reset_i    (reset),
      .src_i      (src),
      .irq_o      (irq),
      .ack_i      (ack),
      .complete_i (complete),
      .id_o       (id),
      .addr_i     (addr),
      .wr_i       (wr),
      .rd_i       (rd),
      .data_i     (wdata),
      .data_o     (rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      addr = a; wdata = d; wr = 1'b1;
      tick();
      wr = 1'b0; wdata = '0;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
      addr = a; rd = 1'b1;
      tick();
      rd = 1'b0;
      d = rdata;
   endtask

   task automatic pulse_src(input int idx);
      src[idx] = 1'b1;
      tick();
      src[idx] = 1'b0;
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   task automatic pulse_complete();
      complete = 1'b1;
      tick();
      complete = 1'b0;
   endtask

   // Wait a bounded number of cycles for irq to reach the wanted level, then check it
   task automatic wait_irq(input string tag, input logic want);
      for (int i = 0; i < 12 && irq !== want; i++) tick();
      check_val(tag, {31'd0, irq}, {31'd0, want});
   endtask

   initial begin
      reset = 1'b1; src = '0; ack = 0; complete = 0;
      addr = '0; wr = 0; rd = 0; wdata = '0;
      #12;
      check_val("reset_irq", {31'd0, irq}, 32'd0);
      check_val("reset_id", {27'd0, id}, 32'd0);
      check_val("reset_data", rdata, 32'd0);
      reset = 1'b0;
      tick();

      // Single edge source, latency and ack
      bus_wr(2'd1, 32'h04);
      src[2] = 1'b1;
      tick();
      src[2] = 1'b0;
      tick();
      tick();
      check_val("t1_irq_early", {31'd0, irq}, 32'd0);
      bus_rd(2'd0, val);
      check_val("t1_pending", val, 32'h04);
      check_val("t1_irq_up", {31'd0, irq}, 32'd1);
      pulse_ack();
      check_val("t1_irq_ack", {31'd0, irq}, 32'd0);
      check_val("t1_id", {27'd0, id}, 32'd2);
      bus_rd(2'd0, val);
      check_val("t1_pending_clr", val, 32'h00);
      bus_rd(2'd2, val);
      check_val("t1_claim", val, 32'h8000_0002);
      pulse_complete();
      bus_rd(2'd2, val);
      check_val("t1_claim_done", val, 32'h0000_0002);

      // Two simultaneous sources: lowest index first
      bus_wr(2'd1, 32'hFF);
      src[5] = 1'b1; src[1] = 1'b1;
      tick();
      src = '0;
      wait_irq("t2_irq_a", 1'b1);
      pulse_ack();
      check_val("t2_id_a", {27'd0, id}, 32'd1);
      pulse_complete();
      wait_irq("t2_irq_b", 1'b1);
      pulse_ack();
      check_val("t2_id_b", {27'd0, id}, 32'd5);
      pulse_complete();

      // No nesting while in service
      pulse_src(3);
      wait_irq("t3_irq", 1'b1);
      pulse_ack();
      check_val("t3_id", {27'd0, id}, 32'd3);
      pulse_src(0);
      val = 32'd0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (irq !== 1'b0) val = 32'd1;
      end
      check_val("t3_no_nest", val, 32'd0);
      pulse_complete();
      check_val("t3_irq_idle", {31'd0, irq}, 32'd0);
      tick();
      check_val("t3_irq_rearm", {31'd0, irq}, 32'd1);
      pulse_ack();
      check_val("t3_id0", {27'd0, id}, 32'd0);
      pulse_complete();

      // Level source re-requests after complete, drops back to IDLE when released
      src[4] = 1'b1;
      wait_irq("t4_irq", 1'b1);
      pulse_ack();
      check_val("t4_id", {27'd0, id}, 32'd4);
      bus_rd(2'd0, val);
      check_val("t4_pending_level", val, 32'h10);
      pulse_complete();
      wait_irq("t4_rereq", 1'b1);
      src[4] = 1'b0;
      wait_irq("t4_drop", 1'b0);
      bus_rd(2'd2, val);
      check_val("t4_claim", val, 32'h0000_0004);

      // Disabled edge source, set-wins-over-clear, then a real clear
      bus_wr(2'd1, 32'h00);
      pulse_src(0);
      for (int i = 0; i < 5; i++) tick();
      check_val("t5_irq_masked", {31'd0, irq}, 32'd0);
      bus_rd(2'd0, val);
      check_val("t5_pending", val, 32'h01);
      src[0] = 1'b1;
      tick();
      src[0] = 1'b0;
      tick();
      bus_wr(2'd0, 32'h01);
      bus_rd(2'd0, val);
      check_val("t5_set_wins", val, 32'h01);
      bus_wr(2'd0, 32'h01);
      bus_rd(2'd0, val);
      check_val("t5_cleared", val, 32'h00);
      bus_rd(2'd3, val);
      check_val("t5_trig", val, 32'h0000_00EF);
      bus_wr(2'd1, 32'hFFFF_FFFF);
      bus_rd(2'd1, val);
      check_val("t5_enable_width", val, 32'h0000_00FF);

      // Asynchronous reset in the middle of service
      bus_wr(2'd1, 32'h04);
      pulse_src(2);
      wait_irq("t6_irq", 1'b1);
      pulse_ack();
      bus_rd(2'd2, val);
      check_val("t6_claim", val, 32'h8000_0002);
      #3;
      reset = 1'b1;
      #1;
      check_val("t6_rst_irq", {31'd0, irq}, 32'd0);
      check_val("t6_rst_id", {27'd0, id}, 32'd0);
      check_val("t6_rst_data", rdata, 32'd0);
      #12;
      reset = 1'b0;
      tick();
      bus_rd(2'd0, val);
      check_val("t6_pending", val, 32'h00);
      bus_rd(2'd1, val);
      check_val("t6_enable", val, 32'h00);
      check_val("t6_irq_after", {31'd0, irq}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Upstream interrupt aggregator that drives the core's external interrupt request (the future irq_i of the CPU top level).
- Synchronises N raw interrupt sources and latches them as pending, level- or edge-triggered per source.
- Arbitrates fixed priority (lowest index wins) and runs a request/ack/complete handshake with the control matrix.
- Exposes a small word-addressed register window on the data bus so firmware can enable, inspect and clear sources.

Parameters:
- DATA_WIDTH, 32, bus data width.
- NUM_SRC, 8, number of interrupt sources (1..31).
- EDGE_MASK, 8'hFF, per-source trigger: 1 = rising edge, 0 = level.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous active-high reset
- src_i  in  NUM_SRC  raw asynchronous interrupt lines
- irq_o  out  1  interrupt request to control matrix
- ack_i  in  1  one-cycle pulse: core has taken the trap
- complete_i  in  1  one-cycle pulse: core executed mret
- id_o  out  5  index of the interrupt currently in service
- addr_i  in  2  register word offset
- wr_i  in  1  bus write strobe
- rd_i  in  1  bus read strobe
- data_i  in  DATA_WIDTH  bus write data
- data_o  out  DATA_WIDTH  bus read data

Behaviour:
- Reset (async, active-high): all sync flops, pending, enable and id_o = 0; state = IDLE; irq_o = 0; data_o = 0.
- Input path: 2-flop synchroniser per source, then a prev register.
  - Edge source: rise = sync & ~prev.
  - Level source: rise = sync, re-evaluated every cycle.
  - Pending bit sets on the cycle after rise. Total latency from a src_i edge to pending = 3 clocks.
- Register map:
  - 0 PENDING: RO; write-1-to-clear, edge sources only (no effect on level bits).
  - 1 ENABLE: RW, NUM_SRC bits, upper bits read 0.
  - 2 CLAIM: bit31 = in-service, [4:0] = id_o.
  - 3 TRIG: RO, returns EDGE_MASK.
- Bus reads are registered: data_o is valid the cycle after rd_i and holds until the next rd_i.
- Simultaneous set and write-1-to-clear on the same bit: set wins.
- FSM:
  - IDLE → REQ when (pending & enable) != 0. irq_o is registered high from REQ entry.
  - REQ → SERVICE on ack_i:
    - id_o latches the lowest set index of (pending & enable), sampled in the ack cycle.
    - That pending bit clears if the source is edge-type.
    - irq_o drops the same clock.
  - REQ → IDLE if (pending & enable) becomes 0 before ack_i (e.g. firmware disables or clears). irq_o deasserts next cycle.
  - SERVICE → IDLE on complete_i. id_o holds its value. irq_o can reassert at the earliest 1 cycle after IDLE entry.
  - No nesting: while in SERVICE, irq_o = 0 regardless of new pending bits.
- Ignored events:
  - ack_i outside REQ.
  - complete_i outside SERVICE.
- Level source still asserted at complete_i: it re-requests, which is the correct level semantics.
- Reset mid-SERVICE: immediately IDLE; all state cleared.

Decomposition:
- Shared package additions:
  - IrqState enum {IRQ_IDLE, IRQ_REQ, IRQ_SERVICE}.
  - Register offset constants IRQ_PENDING=0, IRQ_ENABLE=1, IRQ_CLAIM=2, IRQ_TRIG=3.
  - IrqIdSize = 5.
- One natural sub-module: irq_sync_edge, a per-source synchroniser plus edge/level detect, instantiated NUM_SRC times with a generate loop.
- The priority encoder stays in the top as a combinational loop.

Test Plan:
- Write ENABLE=0x04, pulse src_i[2] → PENDING=0x04 after 3 clks, irq_o=1 next clk; ack_i → id_o=2, PENDING=0, irq_o=0 same clk.
- ENABLE=0xFF, raise src_i[5] and src_i[1] together, ack → id_o=1; complete → irq_o re-asserts, ack → id_o=5.
- In SERVICE (id 3), pulse src_i[0] → irq_o stays 0 until complete_i, then rises within 2 clks.
- Level source (EDGE_MASK bit 4 = 0) held high: ack then complete → irq_o re-asserts; drop src_i[4] in REQ → back to IDLE, irq_o=0.
- Edge source pending while enable=0: irq_o stays 0; write PENDING=0x01 in the same cycle as a new edge → bit stays set; a later write clears it.
- Assert reset_i mid-SERVICE (async, off clock edge) → irq_o, id_o, PENDING, ENABLE read 0 immediately and after release.
